// File: rtl/output_write_controller.sv
// Moves one finished result word into the output FIFO, reports the outcome on stall,
// and tracks a full-FIFO timeout, a wrapping write counter and a sticky overrun flag.
module output_write_controller #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chip_en,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  of_full,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [1:0]            stall,
  output logic                  busy,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  write_count
);

  localparam int unsigned WAIT_W     = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam bit          TIMEOUT_EN = (MAX_WAIT != 0);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_WRITE      = 3'd2,
    S_ACK        = 3'd3,
    S_FAIL       = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic [WAIT_W-1:0]     wait_inc_c;

  // State and datapath registers; chip_en low holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      wait_cnt_q <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  assign wait_inc_c = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

  // Next-state and register-update logic.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    wait_cnt_d = wait_cnt_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    if (chip_en) begin
      if (done && (state_q != S_IDLE)) overrun_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (done) begin
            data_d     = result;
            wait_cnt_d = '0;
            state_d    = S_WAIT_SPACE;
          end
        end
        S_WAIT_SPACE: begin
          // Space wins over timeout when both happen in the same cycle.
          if (!of_full) begin
            state_d = S_WRITE;
          end else begin
            wait_cnt_d = wait_inc_c;
            if (TIMEOUT_EN && (wait_inc_c == WAIT_W'(MAX_WAIT))) state_d = S_FAIL;
          end
        end
        S_WRITE: begin
          count_d = count_q + CNT_WIDTH'(1);
          state_d = S_ACK;
        end
        S_ACK:   state_d = S_IDLE;
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode; the write strobe is gated by the enable so a frozen WRITE never strobes.
  always_comb begin
    wen         = 1'b0;
    stall       = 2'b00;
    busy        = 1'b0;
    wdata       = data_q;
    overrun     = overrun_q;
    write_count = count_q;
    unique case (state_q)
      S_IDLE:       ;
      S_WAIT_SPACE: busy = 1'b1;
      S_WRITE: begin
        busy = 1'b1;
        wen  = chip_en;
      end
      S_ACK: begin
        busy  = 1'b1;
        stall = 2'b10;
      end
      S_FAIL:  stall = 2'b11;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_output_write_controller.sv
// Directed self-checking bench for output_write_controller (default parameters).
module tb_output_write_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        chip_en;
  logic        done;
  logic [15:0] result;
  logic        of_full;
  logic        wen;
  logic [15:0] wdata;
  logic [1:0]  stall;
  logic        busy;
  logic        overrun;
  logic [7:0]  write_count;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  output_write_controller #(.DATA_WIDTH(16), .MAX_WAIT(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .chip_en(chip_en), .done(done), .result(result),
    .of_full(of_full), .wen(wen), .wdata(wdata), .stall(stall), .busy(busy),
    .overrun(overrun), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then driven, outputs checked 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cyc();
    reset = 1'b1; done = 1'b0; of_full = 1'b0; chip_en = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    reset = 1'b1; chip_en = 1'b0; done = 1'b1; result = 16'hFFFF; of_full = 1'b1;
    cyc();
    #1;
    vec_cnt++;
    if ({wen, wdata, stall, busy, overrun, write_count} !== 29'd0)
      begin miss_cnt++; $display("FAIL reset_outputs: got wen=%b wdata=%h stall=%b busy=%b ovr=%b cnt=%0d, want all 0",
        wen, wdata, stall, busy, overrun, write_count); end
    reset = 1'b0; chip_en = 1'b1; done = 1'b0; of_full = 1'b0;
  endtask

  task automatic test_basic();
    for (int c = 0; c <= 4; c++) begin
      cyc();
      done = (c == 0); result = 16'h1234; of_full = 1'b0;
      #1;
      vec_cnt++;
      if (wen !== (c == 2)) begin miss_cnt++; $display("FAIL basic_wen c%0d: got %b want %b", c, wen, (c == 2)); end
      vec_cnt++;
      if (stall !== ((c == 3) ? 2'b10 : 2'b00)) begin miss_cnt++; $display("FAIL basic_stall c%0d: got %b", c, stall); end
      vec_cnt++;
      if (busy !== (c >= 1 && c <= 3)) begin miss_cnt++; $display("FAIL basic_busy c%0d: got %b", c, busy); end
      if (c == 2) begin
        vec_cnt++;
        if (wdata !== 16'h1234) begin miss_cnt++; $display("FAIL basic_wdata: got %h want 1234", wdata); end
      end
      if (c == 3) begin
        vec_cnt++;
        if (write_count !== 8'd1) begin miss_cnt++; $display("FAIL basic_count: got %0d want 1", write_count); end
      end
    end
  endtask

  task automatic test_full_wait();
    for (int c = 0; c <= 9; c++) begin
      cyc();
      done = (c == 0); result = 16'h0F0F; of_full = (c >= 1 && c <= 5);
      #1;
      vec_cnt++;
      if (wen !== (c == 7)) begin miss_cnt++; $display("FAIL wait_wen c%0d: got %b want %b", c, wen, (c == 7)); end
      vec_cnt++;
      if (stall !== ((c == 8) ? 2'b10 : 2'b00)) begin miss_cnt++; $display("FAIL wait_stall c%0d: got %b", c, stall); end
    end
    vec_cnt++;
    if (write_count !== 8'd2) begin miss_cnt++; $display("FAIL wait_count: got %0d want 2", write_count); end
  endtask

  task automatic test_space_at_limit();
    for (int c = 0; c <= 19; c++) begin
      cyc();
      done = (c == 0); result = 16'h7777; of_full = (c >= 1 && c <= 15);
      #1;
      vec_cnt++;
      if (wen !== (c == 17)) begin miss_cnt++; $display("FAIL limit_wen c%0d: got %b want %b", c, wen, (c == 17)); end
      vec_cnt++;
      if (stall !== ((c == 18) ? 2'b10 : 2'b00)) begin miss_cnt++; $display("FAIL limit_stall c%0d: got %b", c, stall); end
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c <= 37; c++) begin
      cyc();
      done = (c == 0 || c == 20); result = 16'h4321; of_full = (c >= 1);
      #1;
      vec_cnt++;
      if (stall !== ((c >= 17) ? 2'b11 : 2'b00)) begin miss_cnt++; $display("FAIL timeout_stall c%0d: got %b", c, stall); end
      vec_cnt++;
      if (busy !== (c >= 1 && c <= 16)) begin miss_cnt++; $display("FAIL timeout_busy c%0d: got %b", c, busy); end
      vec_cnt++;
      if (wen !== 1'b0) begin miss_cnt++; $display("FAIL timeout_wen c%0d: got %b want 0", c, wen); end
    end
    cyc();
    reset = 1'b1; done = 1'b0; of_full = 1'b0;
    cyc();
    #1;
    vec_cnt++;
    if ({wen, wdata, stall, busy, overrun, write_count} !== 29'd0)
      begin miss_cnt++; $display("FAIL timeout_reset: got wen=%b wdata=%h stall=%b busy=%b ovr=%b cnt=%0d, want all 0",
        wen, wdata, stall, busy, overrun, write_count); end
    reset = 1'b0;
  endtask

  task automatic test_overrun();
    int wens = 0;
    for (int c = 0; c <= 5; c++) begin
      cyc();
      done = (c <= 1); result = (c == 0) ? 16'hCAFE : 16'hBEEF; of_full = 1'b0;
      #1;
      if (wen === 1'b1) wens++;
      vec_cnt++;
      if (overrun !== (c >= 2)) begin miss_cnt++; $display("FAIL overrun_flag c%0d: got %b want %b", c, overrun, (c >= 2)); end
      if (c == 2) begin
        vec_cnt++;
        if (wdata !== 16'hCAFE) begin miss_cnt++; $display("FAIL overrun_wdata: got %h want cafe", wdata); end
      end
    end
    vec_cnt++;
    if (wens !== 1) begin miss_cnt++; $display("FAIL overrun_wen_count: got %0d want 1", wens); end
  endtask

  task automatic test_chip_en();
    for (int c = 0; c <= 7; c++) begin
      cyc();
      done = (c == 0) || (c == 3); result = (c == 0) ? 16'h5A5A : 16'h0000;
      of_full = 1'b0; chip_en = !(c >= 2 && c <= 4);
      #1;
      vec_cnt++;
      if (wen !== (c == 5)) begin miss_cnt++; $display("FAIL chipen_wen c%0d: got %b want %b", c, wen, (c == 5)); end
      vec_cnt++;
      if (stall !== ((c == 6) ? 2'b10 : 2'b00)) begin miss_cnt++; $display("FAIL chipen_stall c%0d: got %b", c, stall); end
      vec_cnt++;
      if (write_count !== ((c >= 6) ? 8'd1 : 8'd0)) begin miss_cnt++; $display("FAIL chipen_count c%0d: got %0d", c, write_count); end
      if (c == 5) begin
        vec_cnt++;
        if (wdata !== 16'h5A5A) begin miss_cnt++; $display("FAIL chipen_wdata: got %h want 5a5a", wdata); end
      end
      vec_cnt++;
      if (overrun !== 1'b0) begin miss_cnt++; $display("FAIL chipen_overrun c%0d: got %b want 0", c, overrun); end
    end
    chip_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int wens = 0;
    int acks = 0;
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c <= 3; c++) begin
        cyc();
        done = (c == 0); result = 16'(i) ^ 16'hA500; of_full = 1'b0;
        #1;
        if (wen === 1'b1) wens++;
        if (stall === 2'b10) acks++;
        if (c == 2) begin
          vec_cnt++;
          if (wdata !== (16'(i) ^ 16'hA500)) begin miss_cnt++; $display("FAIL b2b_wdata i%0d: got %h", i, wdata); end
        end
        if (c == 3) begin
          vec_cnt++;
          if (write_count !== 8'(i + 1)) begin miss_cnt++; $display("FAIL b2b_count i%0d: got %0d want %0d", i, write_count, 8'(i + 1)); end
        end
      end
    end
    vec_cnt++;
    if (write_count !== 8'd0) begin miss_cnt++; $display("FAIL b2b_wrap: got %0d want 0", write_count); end
    vec_cnt++;
    if (wens !== 256) begin miss_cnt++; $display("FAIL b2b_wens: got %0d want 256", wens); end
    vec_cnt++;
    if (acks !== 256) begin miss_cnt++; $display("FAIL b2b_acks: got %0d want 256", acks); end
  endtask

  initial begin
    reset = 1'b1; chip_en = 1'b1; done = 1'b0; result = '0; of_full = 1'b0;
    test_reset();
    test_basic();
    test_full_wait();
    test_space_at_limit();
    test_timeout();
    test_overrun();
    apply_reset();
    test_chip_en();
    apply_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
